pe_stream_tx: RTL and testbench
===============================

# pe_stream_tx

Transmit-side endpoint for the PE-array packed stream protocol: drives one `{enable, data}` input bus of a PE wrapper (ifmap, filter or ipsum) and that PE's configuration bus. On `start` it latches a mapping configuration, issues one `set_info` config beat, then forwards exactly `beat_count` words from a buffer-side valid/ready source onto the packed bus, honouring the PE's `ready` backpressure. It sits between the global buffer read port and each PE wrapper's input port, one instance per stream.

## Interface
- `DATA_SIZE`, 8, bits per data element
- `DATA_NUM`, 1, elements per beat (4 for the filter stream)
- `CNT_W`, 16, width of the beat counter
- `CONFIG_BIT`, 39, index of the `set_info` bit in the config word; the config word is `CONFIG_BIT+1` bits
- `CONFIG_Q_BIT`/`P`/`U`/`S`/`F`/`W`, 2/5/4/4/12/12, config field widths

- `clk`  in  1  clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  one-cycle request, sampled only in IDLE
- `beat_count`  in  CNT_W  beats to send, latched on accepted `start`
- `cfg_q`, `cfg_p`, `cfg_U`, `cfg_S`, `cfg_F`, `cfg_W`  in  field widths  mapping config, latched on accepted `start`
- `src_data`  in  DATA_NUM*DATA_SIZE  source word
- `src_valid`  in  1  source word available
- `src_ready`  out  1  source word taken this cycle
- `tx_out`  out  DATA_NUM*DATA_SIZE+1  `{enable, data}` to PE; enable is the MSB
- `tx_ready`  in  1  PE accepts the beat
- `config_out`  out  CONFIG_BIT+1  `{set_info, fields}` to PE
- `busy`  out  1  high in every state except IDLE
- `done`  out  1  one-cycle pulse after the last beat is accepted

## Operation
- FSM states: IDLE, CFG, STREAM, DONE.
- IDLE: if `start` is high, latch `beat_count` and the config fields, then go to CFG. Otherwise `start` is ignored, including in every non-IDLE state.
- CFG: lasts exactly one cycle. `config_out` is registered, so `set_info` is 1 with the latched fields during this cycle. Next state is STREAM, or DONE if the latched count is 0.
- `config_out` carries the latched fields at all times; `set_info` is 1 only in CFG.
- Field packing uses package constants Q@0, P@2, U@7, S@11, F@15, W@27, set_info@`CONFIG_BIT`.
- STREAM uses a single output register (`tx_out` enable + data) and two counters:
  - `loaded` counts words taken from the source.
  - `sent` counts beats accepted by the PE.
- Source handshake: `src_ready = (state==STREAM) && (loaded < count) && (!out_enable || tx_ready)`. This is combinational from registered state and `tx_ready`. A word moves when `src_valid && src_ready`.
- PE handshake: a beat is accepted on a rising edge where enable && `tx_ready`.
  - While enable is high and `tx_ready` is low, data and enable hold stable.
  - On acceptance with a simultaneous source transfer, the register reloads, giving one beat per cycle.
  - On acceptance with no source transfer, enable clears.
- When accepted beats reach the count, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE.
- `sent` and `loaded` are CNT_W wide and never wrap, because `loaded` is capped at the count.
- Reset at any time, including mid-stream: the state returns to IDLE and any in-flight beat is dropped. There is no partial-completion `done`.

## Timing
- Reset values:
  - `tx_out` = 0, `config_out` = 0, `busy` = 0, `done` = 0, `src_ready` = 0.
  - Counters = 0, state = IDLE.
- `start` at cycle 0 → CFG in cycle 1 (`set_info`=1, `busy`=1) → STREAM from cycle 2, where `src_ready` can be high in the same cycle.
- Source-to-PE latency: one cycle. A word taken at edge n appears on `tx_out` after edge n.
- Throughput: one beat per cycle when `src_valid` and `tx_ready` are held high.
- With N≥1 and no stalls, `done` rises in cycle N+3; with N=0, in cycle 2.
- `tx_ready` is ignored while enable=0.

## Structure
- Shared package (or the existing mapping-config include):
  - Config field start offsets
  - `CONFIG_BIT`
  - State encoding
- One natural sub-module: `pe_tx_stage`, the single-entry output register with the enable/hold/reload logic.
- FSM, counters and config latch stay in the top module.

## Test plan
- **Basic stream:** `beat_count`=4, words 0x11..0x44 with `src_valid`=1 and `tx_ready`=1.
  - `config_out[39]`=1 for exactly cycle 1.
  - `tx_out` = 0x111, 0x122, 0x133, 0x144 on consecutive cycles.
  - `done` in cycle 7.
- **PE backpressure:** `beat_count`=3, `tx_ready` low for 3 cycles on beat 2.
  - 0x1_22 holds stable throughout the stall.
  - `src_ready`=0 during the stall.
  - No word is lost or duplicated.
- **Source bubbles:** `src_valid` alternates 1/0.
  - Enable drops to 0 in bubble cycles.
  - All `beat_count` words arrive in order.
- **Zero count:** `beat_count`=0.
  - One CFG cycle, then `done` in cycle 2.
  - `src_ready` never high; `tx_out` enable never high.
- **Start while busy:** pulse `start` with a new config during STREAM.
  - Ignored: config fields are unchanged and the count is unchanged.
- **Reset mid-stream:** assert `rst` after 2 of 5 beats.
  - Next cycle all outputs are at their reset values and no `done` is produced.
  - A following `start` runs a clean 5-beat transfer.

Source files
------------

// File: rtl/pe_stream_tx_pkg.sv
// Shared constants for the PE-array packed stream transmit endpoint:
// mapping-config field offsets, config word width and FSM state encoding.
package pe_stream_tx_pkg;

  // Index of the set_info bit; the config word is CONFIG_BIT+1 bits wide.
  localparam int unsigned CONFIG_BIT = 39;

  localparam int unsigned CONFIG_Q_BIT = 2;
  localparam int unsigned CONFIG_P_BIT = 5;
  localparam int unsigned CONFIG_U_BIT = 4;
  localparam int unsigned CONFIG_S_BIT = 4;
  localparam int unsigned CONFIG_F_BIT = 12;
  localparam int unsigned CONFIG_W_BIT = 12;

  localparam int unsigned CfgQOff = 0;
  localparam int unsigned CfgPOff = 2;
  localparam int unsigned CfgUOff = 7;
  localparam int unsigned CfgSOff = 11;
  localparam int unsigned CfgFOff = 15;
  localparam int unsigned CfgWOff = 27;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StCfg    = 2'd1;
  localparam logic [1:0] StStream = 2'd2;
  localparam logic [1:0] StDone   = 2'd3;

endpackage

// File: rtl/pe_tx_stage.sv
// Single-entry output register driving the packed {enable, data} bus of a PE:
// holds while stalled, reloads on accept+load, clears enable on accept alone.
module pe_tx_stage #(
  parameter int unsigned DataW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [DataW-1:0] data_i,
  input  logic             ready_i,
  output logic [DataW:0]   tx_o,
  output logic             en_o,
  output logic             accept_o
);
  import pe_stream_tx_pkg::*;

  logic             en_q, en_d;
  logic [DataW-1:0] data_q, data_d;

  assign accept_o = en_q & ready_i;
  assign en_o     = en_q;
  assign tx_o     = {en_q, data_q};

  // The caller only loads when the slot is empty or being accepted this edge.
  always_comb begin
    en_d   = en_q;
    data_d = data_q;
    if (load_i) begin
      en_d   = 1'b1;
      data_d = data_i;
    end else if (accept_o) begin
      en_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en_q   <= 1'b0;
      data_q <= '0;
    end else begin
      en_q   <= en_d;
      data_q <= data_d;
    end
  end

  a_hold_stable: assert property (@(posedge clk) disable iff (rst)
    (en_q && !ready_i) |=> (en_q && $stable(data_q)));

endmodule

// File: rtl/pe_stream_tx.sv
// Transmit endpoint for one PE input stream: latches a mapping config on start,
// issues one set_info beat, then forwards beat_count source words to the PE.
module pe_stream_tx #(
  parameter int unsigned DATA_SIZE    = 8,
  parameter int unsigned DATA_NUM     = 1,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned CONFIG_BIT   = pe_stream_tx_pkg::CONFIG_BIT,
  parameter int unsigned CONFIG_Q_BIT = pe_stream_tx_pkg::CONFIG_Q_BIT,
  parameter int unsigned CONFIG_P_BIT = pe_stream_tx_pkg::CONFIG_P_BIT,
  parameter int unsigned CONFIG_U_BIT = pe_stream_tx_pkg::CONFIG_U_BIT,
  parameter int unsigned CONFIG_S_BIT = pe_stream_tx_pkg::CONFIG_S_BIT,
  parameter int unsigned CONFIG_F_BIT = pe_stream_tx_pkg::CONFIG_F_BIT,
  parameter int unsigned CONFIG_W_BIT = pe_stream_tx_pkg::CONFIG_W_BIT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [CNT_W-1:0]               beat_count,
  input  logic [CONFIG_Q_BIT-1:0]        cfg_q,
  input  logic [CONFIG_P_BIT-1:0]        cfg_p,
  input  logic [CONFIG_U_BIT-1:0]        cfg_U,
  input  logic [CONFIG_S_BIT-1:0]        cfg_S,
  input  logic [CONFIG_F_BIT-1:0]        cfg_F,
  input  logic [CONFIG_W_BIT-1:0]        cfg_W,
  input  logic [DATA_NUM*DATA_SIZE-1:0]  src_data,
  input  logic                           src_valid,
  output logic                           src_ready,
  output logic [DATA_NUM*DATA_SIZE:0]    tx_out,
  input  logic                           tx_ready,
  output logic [CONFIG_BIT:0]            config_out,
  output logic                           busy,
  output logic                           done
);
  import pe_stream_tx_pkg::*;

  localparam int unsigned DataW = DATA_NUM * DATA_SIZE;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  loaded_q, loaded_d;
  logic [CNT_W-1:0]  sent_q, sent_d;
  logic [CONFIG_BIT:0] config_q, config_d;
  logic [CONFIG_BIT:0] cfg_word;

  logic tx_en;
  logic accept;
  logic src_fire;

  assign src_ready = (state_q == StStream) && (loaded_q < count_q) && (!tx_en || tx_ready);
  assign src_fire  = src_valid & src_ready;
  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StDone);
  assign config_out = config_q;

  always_comb begin
    cfg_word = '0;
    cfg_word[CONFIG_BIT]                  = 1'b1;
    cfg_word[CfgQOff +: CONFIG_Q_BIT]     = cfg_q;
    cfg_word[CfgPOff +: CONFIG_P_BIT]     = cfg_p;
    cfg_word[CfgUOff +: CONFIG_U_BIT]     = cfg_U;
    cfg_word[CfgSOff +: CONFIG_S_BIT]     = cfg_S;
    cfg_word[CfgFOff +: CONFIG_F_BIT]     = cfg_F;
    cfg_word[CfgWOff +: CONFIG_W_BIT]     = cfg_W;
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    loaded_d = loaded_q;
    sent_d   = sent_q;
    config_d = config_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          count_d  = beat_count;
          loaded_d = '0;
          sent_d   = '0;
          config_d = cfg_word;
          state_d  = StCfg;
        end
      end
      StCfg: begin
        config_d[CONFIG_BIT] = 1'b0;
        state_d = (count_q == '0) ? StDone : StStream;
      end
      StStream: begin
        if (src_fire) begin
          loaded_d = loaded_q + CNT_W'(1);
        end
        if (accept) begin
          sent_d = sent_q + CNT_W'(1);
          if (sent_d == count_q) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      count_q  <= '0;
      loaded_q <= '0;
      sent_q   <= '0;
      config_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      loaded_q <= loaded_d;
      sent_q   <= sent_d;
      config_q <= config_d;
    end
  end

  pe_tx_stage #(
    .DataW (DataW)
  ) u_stage (
    .clk      (clk),
    .rst      (rst),
    .load_i   (src_fire),
    .data_i   (src_data),
    .ready_i  (tx_ready),
    .tx_o     (tx_out),
    .en_o     (tx_en),
    .accept_o (accept)
  );

  a_loaded_capped: assert property (@(posedge clk) disable iff (rst) loaded_q <= count_q);
  a_sent_capped:   assert property (@(posedge clk) disable iff (rst) sent_q <= loaded_q);
  a_done_pulse:    assert property (@(posedge clk) disable iff (rst) done |=> !done);

endmodule

// File: tb/tb_pe_stream_tx.sv
// Randomized scoreboard bench for pe_stream_tx: expected beats are queued at
// stimulus time and a separate monitor pops/compares on every accepted beat.
module tb_pe_stream_tx;
  localparam int unsigned DATA_SIZE  = 8;
  localparam int unsigned DATA_NUM   = 1;
  localparam int unsigned CNT_W      = 16;
  localparam int unsigned CONFIG_BIT = 39;
  localparam int unsigned DW         = DATA_SIZE * DATA_NUM;

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [CNT_W-1:0]    beat_count;
  logic [1:0]          cfg_q;
  logic [4:0]          cfg_p;
  logic [3:0]          cfg_U;
  logic [3:0]          cfg_S;
  logic [11:0]         cfg_F;
  logic [11:0]         cfg_W;
  logic [DW-1:0]       src_data;
  logic                src_valid;
  logic                src_ready;
  logic [DW:0]         tx_out;
  logic                tx_ready;
  logic [CONFIG_BIT:0] config_out;
  logic                busy;
  logic                done;

  always #5 clk = ~clk;

  pe_stream_tx dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .beat_count (beat_count),
    .cfg_q      (cfg_q),
    .cfg_p      (cfg_p),
    .cfg_U      (cfg_U),
    .cfg_S      (cfg_S),
    .cfg_F      (cfg_F),
    .cfg_W      (cfg_W),
    .src_data   (src_data),
    .src_valid  (src_valid),
    .src_ready  (src_ready),
    .tx_out     (tx_out),
    .tx_ready   (tx_ready),
    .config_out (config_out),
    .busy       (busy),
    .done       (done)
  );

  logic [DW-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int n_acc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
    end
  endtask

  // Monitor: enable must follow the handshake rules, stalled beats must hold,
  // and every accepted beat must be the next word the scoreboard expects.
  logic          mon_exp_en = 1'b0;
  logic          mon_prev_stall = 1'b0;
  logic [DW:0]   mon_prev_out = '0;
  logic [DW-1:0] mon_e;

  always @(negedge clk) begin
    if (!rst) begin
      check("tx_enable", 64'(tx_out[DW]), 64'(mon_exp_en));
      if (mon_prev_stall) check("hold_stable", 64'(tx_out), 64'(mon_prev_out));
      if (tx_out[DW] && !tx_ready) check("src_ready_in_stall", 64'(src_ready), 64'd0);
      if (tx_out[DW] && tx_ready) begin
        n_acc++;
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 64'd1, 64'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("beat_data", 64'(tx_out), 64'({1'b1, mon_e}));
        end
      end
      mon_exp_en     = (src_valid && src_ready) || (tx_out[DW] && !tx_ready);
      mon_prev_stall = tx_out[DW] && !tx_ready;
      mon_prev_out   = tx_out;
    end else begin
      mon_exp_en     = 1'b0;
      mon_prev_stall = 1'b0;
    end
  end

  // vmode: 0 = always valid, 1 = alternating, 2 = random 70%.
  task automatic run_txn(input int n, input int vmode, input int rpct, input bit fixed,
                         input int stall_from, input int restart_at, input int abort_after,
                         input int exp_done);
    logic [DW-1:0]       words[$];
    logic [1:0]          q;
    logic [4:0]          p;
    logic [3:0]          u, s;
    logic [11:0]         f, w;
    logic [CONFIG_BIT:0] exp_cfg;
    int  idx = 0;
    int  c;
    int  done_c = -1;
    int  acc0;
    bit  saw_sr = 0, saw_en = 0, saw_done = 0, v;

    q = 2'($urandom); p = 5'($urandom); u = 4'($urandom); s = 4'($urandom);
    f = 12'($urandom); w = 12'($urandom);
    exp_cfg = {1'b1, w, f, s, u, p, q};
    for (int i = 0; i < n; i++) begin
      words.push_back(fixed ? DW'(32'h11 * (i + 1)) : DW'($urandom));
      exp_q.push_back(words[i]);
    end

    @(posedge clk); #1;
    acc0 = n_acc;
    start = 1'b1; beat_count = CNT_W'(n);
    cfg_q = q; cfg_p = p; cfg_U = u; cfg_S = s; cfg_F = f; cfg_W = w;
    src_valid = 1'b0; tx_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; beat_count = CNT_W'($urandom);
    cfg_q = 2'($urandom); cfg_p = 5'($urandom); cfg_U = 4'($urandom); cfg_S = 4'($urandom);
    cfg_F = 12'($urandom); cfg_W = 12'($urandom);
    c = 1;
    while (c < 400) begin
      if (c == restart_at) begin
        start = 1'b1; beat_count = CNT_W'(n + 3);
        cfg_q = ~q; cfg_p = ~p; cfg_U = ~u; cfg_S = ~s; cfg_F = ~f; cfg_W = ~w;
      end else begin
        start = 1'b0;
      end
      v = (idx < n) && (vmode == 0 || (vmode == 1 && c % 2 == 0) ||
                        (vmode == 2 && $urandom_range(99) < 70));
      src_valid = v;
      src_data  = (idx < n) ? words[idx] : DW'($urandom);
      tx_ready  = (c >= stall_from && c < stall_from + 3) ? 1'b0 : ($urandom_range(99) < rpct);
      if (abort_after >= 0 && n_acc - acc0 >= abort_after) begin
        rst = 1'b1; src_valid = 1'b0; start = 1'b0;
        @(posedge clk); #1;
        check("rst_tx_out", 64'(tx_out), 64'd0);
        check("rst_config_out", 64'(config_out), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_src_ready", 64'(src_ready), 64'd0);
        rst = 1'b0;
        exp_q.delete();
        for (int k = 0; k < 6; k++) begin
          @(negedge clk);
          if (done) saw_done = 1;
          @(posedge clk); #1;
        end
        check("no_done_after_reset", 64'(saw_done), 64'd0);
        return;
      end
      @(negedge clk);
      if (c == 1) begin
        check("cfg_set_info", 64'(config_out), 64'(exp_cfg));
        check("busy_in_cfg", 64'(busy), 64'd1);
      end
      if (c == 2) check("set_info_clear", 64'(config_out[CONFIG_BIT]), 64'd0);
      if (src_ready) saw_sr = 1;
      if (tx_out[DW]) saw_en = 1;
      if (src_valid && src_ready) idx++;
      if (done) begin
        done_c = c;
        break;
      end
      @(posedge clk); #1;
      c++;
    end

    if (done_c < 0) check("done_timeout", 64'd0, 64'd1);
    else if (exp_done >= 0) check("done_cycle", 64'(done_c), 64'(exp_done));
    check("all_beats_delivered", 64'(exp_q.size()), 64'd0);
    check("words_loaded", 64'(idx), 64'(n));
    check("cfg_fields_kept", 64'(config_out), 64'({1'b0, exp_cfg[CONFIG_BIT-1:0]}));
    @(posedge clk); #1;
    src_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    check("done_one_cycle", 64'(done), 64'd0);
    check("idle_not_busy", 64'(busy), 64'd0);
    if (n == 0) begin
      check("zero_no_src_ready", 64'(saw_sr), 64'd0);
      check("zero_no_enable", 64'(saw_en), 64'd0);
    end
    exp_q.delete();
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; beat_count = '0;
    cfg_q = '0; cfg_p = '0; cfg_U = '0; cfg_S = '0; cfg_F = '0; cfg_W = '0;
    src_data = '0; src_valid = 1'b0; tx_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx_out", 64'(tx_out), 64'd0);
    check("reset_config_out", 64'(config_out), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_src_ready", 64'(src_ready), 64'd0);
    rst = 1'b0;

    run_txn(4, 0, 100, 1'b1, -1, -1, -1, 7);   // basic stream
    run_txn(3, 0, 100, 1'b1,  4, -1, -1, 9);   // PE stall on beat 2
    run_txn(6, 1, 100, 1'b0, -1, -1, -1, -1);  // source bubbles
    run_txn(0, 0, 100, 1'b0, -1, -1, -1, 2);   // zero count
    run_txn(5, 0, 100, 1'b0, -1,  4, -1, 8);   // start while busy
    run_txn(5, 0, 100, 1'b0, -1, -1,  2, -1);  // reset mid-stream
    run_txn(5, 0, 100, 1'b0, -1, -1, -1, 8);   // clean run after reset
    for (int t = 0; t < 20; t++) begin
      run_txn(int'($urandom_range(12, 1)), 2, int'($urandom_range(100, 40)), 1'b0,
              -1, -1, -1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
